// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable baud divisor, data width, parity, stop bits.
// Latency: a byte accepted at edge N into an idle, empty block drives the start bit from edge N+1.
// Backpressure: in_ready drops when the FIFO is full; writes while full are dropped and set sticky overflow.
// Optional feature: define UART_TX_CRLF_EN to send 8'h0D ahead of every 8'h0A, back-to-back.
module uart_tx_fifo #(
    parameter int CLK_DIV   = 1,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             uart_tx_pin,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow,
    input  logic             overflow_clr
);
    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    state_t             state;
    logic [7:0]         shreg;
    logic               par_bit;
    logic [2:0]         bit_cnt;
    logic [15:0]        baud_cnt;
    logic               stop_cnt;

    logic               push;
    logic               pop;
    logic               load;
    logic               fifo_empty;
    logic               baud_done;
    logic               frame_end;
    logic [7:0]         head;
    logic [7:0]         next_byte;
    logic               next_par;

    // Full/empty come from the registered level only, so a same-cycle pop never frees a slot early.
    assign fifo_empty = (fifo_level == '0);
    assign in_ready   = (fifo_level != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr] & DATA_MASK;
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign frame_end  = (state == S_STOP) && baud_done && (stop_cnt == STOP_LAST);
    assign busy       = (state != S_IDLE) || !fifo_empty;
    // Odd parity makes data+parity ones odd, even makes it even; unused when PARITY is 0.
    assign next_par   = (PARITY == 1) ? ~(^next_byte) : (^next_byte);

`ifdef UART_TX_CRLF_EN
    logic pend_vld;

    // A new frame starts from idle or straight out of the last stop bit; a pending LF wins over the FIFO.
    assign load      = ((state == S_IDLE) || frame_end) && (!fifo_empty || pend_vld);
    assign pop       = load && !pend_vld;
    assign next_byte = pend_vld ? 8'h0A : ((head == 8'h0A) ? 8'h0D : head);

    // Hold the popped LF while its inserted CR goes out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_vld <= !pend_vld && (head == 8'h0A);
        end
    end
`else
    assign load      = ((state == S_IDLE) || frame_end) && !fifo_empty;
    assign pop       = load;
    assign next_byte = head;
`endif

    // Storage array: no reset needed, validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally at 2**FIFO_AW; level tracks push/pop, unchanged when both happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Frame sequencer: the baud counter restarts on every bit boundary; the line output is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            par_bit     <= 1'b0;
            bit_cnt     <= '0;
            baud_cnt    <= '0;
            stop_cnt    <= 1'b0;
            uart_tx_pin <= 1'b1;
        end else if (load) begin
            state       <= S_START;
            shreg       <= next_byte;
            par_bit     <= next_par;
            baud_cnt    <= '0;
            uart_tx_pin <= 1'b0;
        end else if (state == S_IDLE) begin
            baud_cnt    <= '0;
            uart_tx_pin <= 1'b1;
        end else if (!baud_done) begin
            baud_cnt <= baud_cnt + 16'd1;
        end else begin
            baud_cnt <= '0;
            case (state)
                S_START: begin
                    state       <= S_DATA;
                    bit_cnt     <= '0;
                    uart_tx_pin <= shreg[0];
                end
                S_DATA: begin
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt     <= bit_cnt + 3'd1;
                        shreg       <= {1'b0, shreg[7:1]};
                        uart_tx_pin <= shreg[1];
                    end else if (PARITY != 0) begin
                        state       <= S_PARITY;
                        uart_tx_pin <= par_bit;
                    end else begin
                        state       <= S_STOP;
                        stop_cnt    <= 1'b0;
                        uart_tx_pin <= 1'b1;
                    end
                end
                S_PARITY: begin
                    state       <= S_STOP;
                    stop_cnt    <= 1'b0;
                    uart_tx_pin <= 1'b1;
                end
                S_STOP: begin
                    if (stop_cnt == STOP_LAST) begin
                        state       <= S_IDLE;
                        uart_tx_pin <= 1'b1;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    uart_tx_pin <= 1'b1;
                end
            endcase
        end
    end

endmodule
